// File: rtl/hub_pkg.sv
// hub_pkg: shared cog count, size codes and pipeline record for the hub sequencer.
package hub_pkg;
  localparam int NCOG = 8;
  typedef enum logic [1:0] {BYTE = 2'b00, WORD = 2'b01, LONG = 2'b10} hub_sz_e;
  typedef struct packed {
    logic       v;
    logic [2:0] cog;
    logic [1:0] sz;
    logic [1:0] off;
  } stage1_t;
endpackage

// File: rtl/hub_lane.sv
// hub_lane: write lane encode/replicate and read alignment/zero-extension.
module hub_lane import hub_pkg::*; (
  input  logic [1:0]  w_sz,
  input  logic [1:0]  w_off,
  input  logic [31:0] w_data,
  output logic [3:0]  wb,
  output logic [31:0] d,
  input  logic [1:0]  r_sz,
  input  logic [1:0]  r_off,
  input  logic [31:0] q,
  output logic [31:0] rd
);
  logic [31:0] sh;
  always_comb begin
    wb = w_sz == BYTE ? 4'b0001 << w_off : w_sz == WORD ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    d  = w_sz == BYTE ? {4{w_data[7:0]}} : w_sz == WORD ? {2{w_data[15:0]}} : w_data;
    sh = r_sz == BYTE ? q >> {r_off, 3'b000} : r_sz == WORD ? q >> {r_off[1], 4'b0000} : q;
    rd = r_sz == BYTE ? {24'd0, sh[7:0]} : r_sz == WORD ? {16'd0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/hub_seq.sv
// hub_seq: round-robin hub slot sequencer; grant at slot, data+ack two enabled cycles later.
module hub_seq import hub_pkg::*; (
  input  logic              clk_cog,
  input  logic              res,
  input  logic              ena_bus,
  input  logic [NCOG-1:0]   req,
  input  logic [NCOG-1:0]   we,
  input  logic [15:0]       sz,
  input  logic [127:0]      addr,
  input  logic [255:0]      wdata,
  output logic [NCOG-1:0]   ack,
  output logic [31:0]       rdata,
  output logic              mem_w,
  output logic [3:0]        mem_wb,
  output logic [13:0]       mem_a,
  output logic [31:0]       mem_d,
  input  logic [31:0]       mem_q
);
  logic [2:0]      slot_q, slot_d;
  stage1_t         s1_q, s1_d;
  logic [NCOG-1:0] ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d, rd_al, g_wdata;
  logic [1:0]      g_sz;
  logic [15:0]     g_addr;
  logic [3:0]      lane_wb;
  logic            grant, fin;
  hub_lane u_lane (
    .w_sz(g_sz), .w_off(g_addr[1:0]), .w_data(g_wdata), .wb(lane_wb), .d(mem_d),
    .r_sz(s1_q.sz), .r_off(s1_q.off), .q(mem_q), .rd(rd_al)
  );
  always_comb begin
    g_sz    = sz[slot_q*2 +: 2];
    g_addr  = addr[slot_q*16 +: 16];
    g_wdata = wdata[slot_q*32 +: 32];
    grant   = ena_bus && !res && req[slot_q];
    mem_w   = grant && we[slot_q];
    mem_wb  = grant && we[slot_q] ? lane_wb : 4'b0000;
    mem_a   = g_addr[15:2];
    slot_d  = ena_bus ? slot_q + 3'd1 : slot_q;
    s1_d    = ena_bus ? stage1_t'{grant, slot_q, g_sz, g_addr[1:0]} : s1_q;
    fin     = ena_bus && s1_q.v;
    ack_d   = fin ? {{(NCOG-1){1'b0}}, 1'b1} << s1_q.cog : '0;
    rdata_d = fin ? rd_al : rdata_q;
  end
  // Stage 1 only advances on enabled cycles, so bus gaps stretch latency without losing the access.
  always_ff @(posedge clk_cog or posedge res) begin
    if (res) begin
      slot_q  <= '0;
      s1_q    <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      slot_q  <= slot_d;
      s1_q    <= s1_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end
  assign ack   = ack_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_hub_seq.sv
// tb_hub_seq: table-driven vectors plus scoreboard-checked directed sequences for hub_seq.
module tb_hub_seq;
  logic         clk_cog = 1'b0, res = 1'b1, ena_bus = 1'b1;
  logic [7:0]   req = '0, we = '0;
  logic [15:0]  sz = '0;
  logic [127:0] addr = '0;
  logic [255:0] wdata = '0;
  logic [7:0]   ack;
  logic [31:0]  rdata, mem_d, mem_q_r;
  logic         mem_w;
  logic [3:0]   mem_wb;
  logic [13:0]  mem_a;

  hub_seq dut (
    .clk_cog(clk_cog), .res(res), .ena_bus(ena_bus), .req(req), .we(we), .sz(sz),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .mem_w(mem_w),
    .mem_wb(mem_wb), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q_r)
  );

  always #5 clk_cog = ~clk_cog;

  int n_vec = 0, n_err = 0;
  logic [31:0] mem [0:16383];
  logic [2:0]  tb_slot;
  int          en_cnt;
  logic        last_en;

  typedef struct {logic [2:0] cog; logic rd; logic [31:0] d; int en;} exp_t;
  exp_t sbq[$];
  exp_t e_pop;
  logic [15:0] mon_a;

  typedef struct {
    int cog; logic we; logic [1:0] sz; logic [15:0] a; logic [31:0] wd;
    logic [13:0] ea; logic [3:0] ewb; logic [31:0] ed; logic [31:0] erd;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] m, input logic [1:0] s, input logic [1:0] o);
    if (s == 2'b00) return (m >> (8 * o)) & 32'h0000_00FF;
    if (s == 2'b01) return o[1] ? {16'h0, m[31:16]} : {16'h0, m[15:0]};
    return m;
  endfunction

  // Hub memory model: registered read, lane-masked write, frozen when ena_bus is low.
  always @(posedge clk_cog) begin
    if (ena_bus) begin
      mem_q_r <= mem[mem_a];
      if (mem_w)
        for (int b = 0; b < 4; b++)
          if (mem_wb[b]) mem[mem_a][8*b +: 8] <= mem_d[8*b +: 8];
    end
  end

  always @(posedge clk_cog or posedge res) begin
    if (res) begin
      tb_slot <= '0;
      en_cnt  <= 0;
      last_en <= 1'b0;
    end else begin
      last_en <= ena_bus;
      if (ena_bus) begin
        tb_slot <= tb_slot + 3'd1;
        en_cnt  <= en_cnt + 1;
      end
    end
  end

  always @(negedge clk_cog) begin
    if (res) sbq.delete();
    else begin
      if (ack != 8'h00) begin
        chk("ack_onehot", {31'd0, $onehot(ack)}, 32'd1);
        if (sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_ack: got %b expected none", ack);
        end else begin
          e_pop = sbq.pop_front();
          chk("ack_cog", {24'd0, ack}, 32'd1 << e_pop.cog);
          chk("ack_latency", en_cnt, e_pop.en + 2);
          if (e_pop.rd) chk("sb_rdata", rdata, e_pop.d);
        end
      end else if (sbq.size() > 0 && last_en && en_cnt >= sbq[0].en + 2) begin
        n_vec++; n_err++;
        $display("FAIL missing_ack: got none expected cog %0d", sbq[0].cog);
        void'(sbq.pop_front());
      end
      if (ena_bus && req[tb_slot]) begin
        mon_a = addr[tb_slot*16 +: 16];
        sbq.push_back('{tb_slot, !we[tb_slot], model_rd(mem[mon_a[15:2]], sz[tb_slot*2 +: 2], mon_a[1:0]), en_cnt});
      end else chk("idle_mem_w_wb", {27'd0, mem_w, mem_wb}, 32'd0);
    end
  end

  task automatic wait_ack(input int c, output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk_cog);
      if (ack[c]) got = 1'b1;
    end
    chk("ack_arrived", {31'd0, got}, 32'd1);
    @(posedge clk_cog); #1;
    req[c] = 1'b0;
  endtask

  task automatic do_vec(input vec_t v);
    bit hit = 1'b0, got;
    @(posedge clk_cog); #1;
    we[v.cog] = v.we;
    sz[v.cog*2 +: 2] = v.sz;
    addr[v.cog*16 +: 16] = v.a;
    wdata[v.cog*32 +: 32] = v.wd;
    req[v.cog] = 1'b1;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_cog);
      if (ena_bus && tb_slot == v.cog[2:0]) hit = 1'b1;
    end
    chk("grant_seen", {31'd0, hit}, 32'd1);
    if (hit) begin
      chk("mem_w", {31'd0, mem_w}, {31'd0, v.we});
      chk("mem_a", {18'd0, mem_a}, {18'd0, v.ea});
      chk("mem_wb", {28'd0, mem_wb}, {28'd0, v.ewb});
      if (v.we) chk("mem_d", mem_d, v.ed);
    end
    wait_ack(v.cog, got);
    if (got && !v.we) chk("vec_rdata", rdata, v.erd);
  endtask

  initial begin
    bit got, hit;
    int n_ack, prev, idx;
    for (int i = 0; i < 16384; i++) mem[i] = (i < 256) ? 32'h1000_0000 + i : 32'h0;
    vt[0] = '{3, 1'b1, 2'b10, 16'h0104, 32'hDEADBEEF, 14'h041, 4'b1111, 32'hDEADBEEF, 32'h0};
    vt[1] = '{3, 1'b0, 2'b00, 16'h0106, 32'h0,        14'h041, 4'b0000, 32'h0,        32'h0000_00AD};
    vt[2] = '{5, 1'b1, 2'b01, 16'h0003, 32'h0000_1234, 14'h000, 4'b1100, 32'h1234_1234, 32'h0};
    vt[3] = '{0, 1'b1, 2'b00, 16'h0011, 32'h0000_005A, 14'h004, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    vt[4] = '{7, 1'b0, 2'b01, 16'h0102, 32'h0,        14'h040, 4'b0000, 32'h0,        32'h0000_1000};
    vt[5] = '{1, 1'b0, 2'b10, 16'h0104, 32'h0,        14'h041, 4'b0000, 32'h0,        32'hDEADBEEF};
    vt[6] = '{2, 1'b1, 2'b00, 16'h0107, 32'h0000_00C3, 14'h041, 4'b1000, 32'hC3C3_C3C3, 32'h0};
    vt[7] = '{4, 1'b0, 2'b11, 16'h0107, 32'h0,        14'h041, 4'b0000, 32'h0,        32'hC3ADBEEF};
    vt[8] = '{6, 1'b0, 2'b00, 16'h0011, 32'h0,        14'h004, 4'b0000, 32'h0,        32'h0000_005A};
    vt[9] = '{2, 1'b0, 2'b01, 16'h0002, 32'h0,        14'h000, 4'b0000, 32'h0,        32'h0000_1234};

    req = 8'hFF; we = 8'hFF; sz = 16'hAAAA;
    @(negedge clk_cog);
    chk("rst_ack", {24'd0, ack}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_w", {31'd0, mem_w}, 32'd0);
    chk("rst_mem_wb", {28'd0, mem_wb}, 32'd0);
    @(posedge clk_cog); #1;
    req = '0; we = '0; sz = '0;
    res = 1'b0;

    foreach (vt[i]) do_vec(vt[i]);

    // All cogs requesting back-to-back: acks must rotate 0..7 one per clock.
    @(posedge clk_cog); #1;
    for (int c = 0; c < 8; c++) begin
      we[c] = 1'b0; sz[c*2 +: 2] = 2'b10; addr[c*16 +: 16] = 16'(c * 4);
    end
    req = 8'hFF;
    n_ack = 0; prev = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_cog);
      if (ack != 8'h00) begin
        idx = 0;
        for (int b = 0; b < 8; b++) if (ack[b]) idx = b;
        if (prev >= 0) chk("ack_order", idx, (prev + 1) % 8);
        prev = idx;
        n_ack++;
      end
    end
    chk("all_ack_count", n_ack, 28);
    @(posedge clk_cog); #1;
    req = '0;
    repeat (4) @(posedge clk_cog);
    #1;

    // Cog0 byte read with ena_bus toggling every clock.
    we[0] = 1'b0; sz[1:0] = 2'b00; addr[15:0] = 16'h0104; req[0] = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 40; k++) begin
      ena_bus = (k % 2 == 0);
      @(negedge clk_cog);
      if (ack[0]) begin
        n_ack++;
        chk("toggle_rdata", rdata, 32'h0000_00EF);
      end
      @(posedge clk_cog); #1;
      if (n_ack > 0) req[0] = 1'b0;
    end
    chk("toggle_ack_count", n_ack, 1);
    ena_bus = 1'b1;

    // Reset one cycle after a cog2 grant: access is dropped, slot restarts at 0.
    we[2] = 1'b0; sz[5:4] = 2'b10; addr[47:32] = 16'h0100; req[2] = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk_cog);
      if (tb_slot == 3'd2) hit = 1'b1;
    end
    chk("cog2_grant_seen", {31'd0, hit}, 32'd1);
    @(posedge clk_cog); #1;
    res = 1'b1; req[2] = 1'b0;
    we[0] = 1'b1; sz[1:0] = 2'b10; addr[15:0] = 16'h0200; wdata[31:0] = 32'hA5A5_A5A5; req[0] = 1'b1;
    @(negedge clk_cog);
    chk("res_mem_w", {31'd0, mem_w}, 32'd0);
    chk("res_mem_wb", {28'd0, mem_wb}, 32'd0);
    chk("res_ack", {24'd0, ack}, 32'd0);
    @(posedge clk_cog); #1;
    res = 1'b0;
    @(negedge clk_cog);
    chk("post_res_rdata", rdata, 32'd0);
    chk("post_res_slot0_w", {31'd0, mem_w}, 32'd1);
    chk("post_res_mem_a", {18'd0, mem_a}, 32'h080);
    chk("post_res_mem_wb", {28'd0, mem_wb}, 32'hF);
    wait_ack(0, got);
    repeat (12) @(posedge clk_cog);
    @(negedge clk_cog);
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
